// File: rtl/spi_eeprom_boot_loader.sv
// rtl/spi_eeprom_boot_loader.sv - SPI EEPROM boot master that copies an image into on-chip memory
//
// Reads LOAD_BYTES from an M95xxx-class SPI EEPROM (READ 0x03, SPI mode 0),
// starting at START_ADDR, and writes them as little-endian DATA_W-bit words.
// Optional feature macro: BOOT_CHECKSUM_EN (one trailing checksum byte is
// read; err flags a nonzero 8-bit sum over image plus checksum).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        one-cycle load request, honoured when idle
//   miso         serial data from EEPROM Q
//   spi_clk_out  SPI clock, idles low
//   mosi_out     serial data to EEPROM D, MSB first
//   spi_en_out   chip select, active low
//   mem_we       one-cycle memory write strobe
//   mem_addr     word address, 0-based
//   mem_wdata    assembled word
//   busy         load in progress
//   done         sticky load-complete flag, cleared by the next start
//   err          checksum failure (constant 0 without BOOT_CHECKSUM_EN)
module spi_eeprom_boot_loader #(
    parameter int ADDR_BYTES = 2,
    parameter int START_ADDR = 0,
    parameter int LOAD_BYTES = 256,
    parameter int DATA_W     = 8,
    parameter int MEM_AW     = 8,
    parameter int CLK_DIV    = 4,
    parameter int AUTO_BOOT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              miso,
    output logic              spi_clk_out,
    output logic              mosi_out,
    output logic              spi_en_out,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BPW = (DATA_W >= 8) ? DATA_W / 8 : 1;
    localparam int TX_BITS = 8 + 8 * ADDR_BYTES;
`ifdef BOOT_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int TOTAL_BYTES = LOAD_BYTES + EXTRA;
    localparam int LOAD_WORDS  = LOAD_BYTES / BPW;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(TX_BITS + 1);
    localparam int BW = $clog2(TOTAL_BYTES + 1);
    localparam logic [31:0] SA = START_ADDR;
    localparam logic [TX_BITS-1:0] TX_WORD = {8'h03, SA[8*ADDR_BYTES-1:0]};

    if (ADDR_BYTES < 1 || ADDR_BYTES > 3 || !(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) ||
        LOAD_BYTES < 1 || (LOAD_BYTES % BPW) != 0 || CLK_DIV < 1 ||
        (64'd1 << MEM_AW) < 64'(LOAD_WORDS)) begin : g_param_err
        $error("spi_eeprom_boot_loader: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD} state_t;

    state_t             state;
    logic [DW-1:0]      div_cnt;
    logic [TX_BITS-2:0] tx_sr;      // bits still to be sent after the one on mosi_out
    logic [TW-1:0]      tx_cnt;
    logic [6:0]         byte_sr;
    logic [2:0]         bit_cnt;
    logic [BW-1:0]      byte_cnt;
    logic [1:0]         lane;
    logic [DATA_W-1:0]  word_sr;
    logic               boot_pending;

    logic               half_done;
    logic               launch;
    logic               finish;
    logic               byte_done;
    logic [7:0]         new_byte;
    logic [DATA_W-1:0]  word_next;

    always_comb begin
        half_done = (div_cnt == DW'(CLK_DIV - 1));
        new_byte  = {byte_sr, miso};
        finish    = (state == CS_HOLD) && spi_en_out;
        // A start in the completion cycle chains straight into a new load.
        launch    = ((state == IDLE) && (start || boot_pending)) || (finish && start);
        byte_done = (state == DATA) && half_done && !spi_clk_out && (bit_cnt == 3'd7);
        word_next = word_sr;
        for (int k = 0; k < BPW; k++) begin
            if (lane == 2'(k)) word_next[8*k +: 8] = new_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            spi_clk_out  <= 1'b0;
            mosi_out     <= 1'b0;
            spi_en_out   <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            boot_pending <= (AUTO_BOOT != 0);
            div_cnt      <= '0;
            tx_sr        <= '0;
            tx_cnt       <= '0;
            byte_sr      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            lane         <= '0;
            word_sr      <= '0;
        end else if (launch) begin
            state        <= CS_SETUP;
            busy         <= 1'b1;
            done         <= 1'b0;
            boot_pending <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            spi_en_out   <= 1'b0;
            spi_clk_out  <= 1'b0;
            mosi_out     <= TX_WORD[TX_BITS-1];
            tx_sr        <= TX_WORD[TX_BITS-2:0];
            tx_cnt       <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            lane         <= '0;
        end else begin
            mem_we <= 1'b0;
            // Address advances the clock after the strobe; it stays on the last word at the end.
            if (mem_we && (mem_addr != MEM_AW'(LOAD_WORDS - 1))) mem_addr <= mem_addr + MEM_AW'(1);
            case (state)
                IDLE: ;
                CS_SETUP: begin
                    if (half_done) begin
                        div_cnt     <= '0;
                        spi_clk_out <= 1'b1;
                        state       <= CMD;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                CMD, ADDR: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_clk_out) begin
                            spi_clk_out <= 1'b1;
                        end else begin
                            spi_clk_out <= 1'b0;
                            mosi_out    <= tx_sr[TX_BITS-2];
                            tx_sr       <= {tx_sr[TX_BITS-3:0], 1'b0};
                            tx_cnt      <= tx_cnt + TW'(1);
                            if (tx_cnt == TW'(7)) state <= ADDR;
                            if (tx_cnt == TW'(TX_BITS - 1)) begin
                                state    <= DATA;
                                mosi_out <= 1'b0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_clk_out) begin
                            // Rising edge: sample miso.
                            spi_clk_out <= 1'b1;
                            byte_sr     <= {byte_sr[5:0], miso};
                            bit_cnt     <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                byte_cnt <= byte_cnt + BW'(1);
                                // The trailing checksum byte never reaches memory.
                                if (byte_cnt < BW'(LOAD_BYTES)) begin
                                    word_sr <= word_next;
                                    if (lane == 2'(BPW - 1)) begin
                                        lane      <= '0;
                                        mem_wdata <= word_next;
                                        mem_we    <= 1'b1;
                                    end else begin
                                        lane <= lane + 2'd1;
                                    end
                                end
                            end
                        end else begin
                            spi_clk_out <= 1'b0;
                            if (byte_cnt == BW'(TOTAL_BYTES)) state <= CS_HOLD;
                        end
                    end
                end
                CS_HOLD: begin
                    if (!spi_en_out) begin
                        if (half_done) begin
                            div_cnt    <= '0;
                            spi_en_out <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (launch) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (byte_done) begin
            sum <= sum + new_byte;
        end else if (finish) begin
            err_q <= (sum != 8'd0);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
